// File: rtl/ecc_correct_stage.sv
// ecc_correct_stage: single-bit error locator/corrector sitting behind the GF(2)
// syndrome multiplier. Captures a codeword and H, samples the registered syndrome
// one cycle later, scans H columns one per cycle and flips the first matching bit.
// Optional feature macro: ECC_ERR_COUNT_EN builds saturating CORRECTED/UNCORRECTABLE
// counters; when undefined corr_cnt and uncorr_cnt are tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cw_ready high, waiting for cw_valid
// CAPTURE | syndrome from the multiplier is sampled this cycle
// SEARCH  | comparing the syndrome against H column j, one column per cycle
// DONE    | result presented, out_valid held until out_ready
module ecc_correct_stage #(
  parameter int CW_WIDTH  = 8,
  parameter int SYN_WIDTH = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SYN_WIDTH*CW_WIDTH-1:0] h_matrix,
  input  logic [CW_WIDTH-1:0]           cw_in,
  input  logic                          cw_valid,
  output logic                          cw_ready,
  input  logic [SYN_WIDTH-1:0]          syndrome_in,
  output logic [CW_WIDTH-1:0]           out_data,
  output logic [1:0]                    out_status,
  output logic [SYN_WIDTH-1:0]          out_syndrome,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CNT_WIDTH-1:0]          corr_cnt,
  output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

  localparam int J_W = (CW_WIDTH > 1) ? $clog2(CW_WIDTH) : 1;

  localparam logic [1:0] ST_CLEAN     = 2'b00;
  localparam logic [1:0] ST_CORRECTED = 2'b01;
  localparam logic [1:0] ST_UNCORR    = 2'b10;

  typedef enum logic [1:0] {IDLE, CAPTURE, SEARCH, DONE} state_t;

  state_t                        state, state_nxt;
  logic [CW_WIDTH-1:0]           cw_q;
  logic [SYN_WIDTH*CW_WIDTH-1:0] h_q;
  logic [SYN_WIDTH-1:0]          syn_q;
  logic [J_W-1:0]                j_q;
  logic [SYN_WIDTH-1:0]          col_j;
  logic                          col_match;
  logic                          last_col;
  logic                          out_fire;

  // Gather column j of the captured H; bit r of the column lives in row r.
  always_comb begin
    col_j = '0;
    for (int r = 0; r < SYN_WIDTH; r++) begin
      col_j[r] = h_q[CW_WIDTH*r + int'(j_q)];
    end
  end

  assign col_match    = (col_j == syn_q);
  assign last_col     = (j_q == J_W'(CW_WIDTH - 1));
  assign out_fire     = out_valid && out_ready;
  assign out_syndrome = syn_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cw_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        cw_ready = 1'b1;
        if (cw_valid) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (syndrome_in == '0) state_nxt = DONE;
        else                   state_nxt = SEARCH;
      end
      SEARCH: begin
        if (col_match || last_col) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture item, then build the result while moving into DONE.
  // Result registers are only written on the way into DONE, so they hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_q       <= '0;
      h_q        <= '0;
      syn_q      <= '0;
      j_q        <= '0;
      out_data   <= '0;
      out_status <= ST_CLEAN;
    end else begin
      case (state)
        IDLE: begin
          if (cw_valid) begin
            cw_q <= cw_in;
            h_q  <= h_matrix;
          end
        end
        CAPTURE: begin
          syn_q <= syndrome_in;
          j_q   <= '0;
          if (syndrome_in == '0) begin
            out_data   <= cw_q;
            out_status <= ST_CLEAN;
          end
        end
        SEARCH: begin
          if (col_match) begin
            out_data   <= cw_q ^ (CW_WIDTH'(1) << j_q);
            out_status <= ST_CORRECTED;
          end else if (last_col) begin
            out_data   <= cw_q;
            out_status <= ST_UNCORR;
          end else begin
            j_q <= j_q + J_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ECC_ERR_COUNT_EN
  // Saturating error counters, bumped on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (out_status == ST_CORRECTED && corr_cnt != '1)
        corr_cnt <= corr_cnt + CNT_WIDTH'(1);
      if (out_status == ST_UNCORR && uncorr_cnt != '1)
        uncorr_cnt <= uncorr_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign corr_cnt   = '0;
  assign uncorr_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_correct_stage.sv
// Scoreboard bench for ecc_correct_stage: the driver pushes the reference-model result
// at each accept; the monitor pops and checks on every output handshake.
module tb_ecc_correct_stage;
  localparam int CW   = 8;
  localparam int SW   = 4;
  localparam int CNTW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [SW*CW-1:0] h_matrix = '0;
  logic [CW-1:0]    cw_in = '0;
  logic             cw_valid = 1'b0;
  logic             cw_ready;
  logic [SW-1:0]    syndrome_in = '0;
  logic [CW-1:0]    out_data;
  logic [1:0]       out_status;
  logic [SW-1:0]    out_syndrome;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CNTW-1:0]  corr_cnt;
  logic [CNTW-1:0]  uncorr_cnt;

  ecc_correct_stage #(.CW_WIDTH(CW), .SYN_WIDTH(SW), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst(rst), .h_matrix(h_matrix), .cw_in(cw_in), .cw_valid(cw_valid),
    .cw_ready(cw_ready), .syndrome_in(syndrome_in), .out_data(out_data),
    .out_status(out_status), .out_syndrome(out_syndrome), .out_valid(out_valid),
    .out_ready(out_ready), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] data;
    logic [1:0]    status;
    logic [SW-1:0] syn;
    int            lat;
    int            acc;
  } exp_t;

  exp_t q[$];
  bit   drv_done = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [SW-1:0] col_of(input logic [SW*CW-1:0] h, input int j);
    logic [SW-1:0] c;
    for (int r = 0; r < SW; r++) c[r] = h[CW*r + j];
    return c;
  endfunction

  function automatic logic [SW*CW-1:0] std_h();
    logic [SW*CW-1:0] h;
    int v;
    h = '0;
    for (int j = 0; j < CW; j++) begin
      v = j + 1;
      for (int r = 0; r < SW; r++) h[CW*r + j] = v[r];
    end
    return h;
  endfunction

  // Reference: first column equal to the syndrome names the bad bit.
  function automatic exp_t model(input logic [CW-1:0] cw, input logic [SW*CW-1:0] h,
                                 input logic [SW-1:0] syn);
    exp_t e;
    bit found;
    e.data = cw; e.syn = syn; e.acc = 0;
    found = 1'b0;
    if (syn == 0) begin
      e.status = 2'b00; e.lat = 2;
    end else begin
      e.status = 2'b10; e.lat = 2 + CW;
      for (int j = 0; j < CW; j++) begin
        if (!found && col_of(h, j) == syn) begin
          found = 1'b1;
          e.data = cw ^ (8'h01 << j);
          e.status = 2'b01;
          e.lat = 3 + j;
        end
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic send(input logic [CW-1:0] cw, input logic [SW*CW-1:0] h,
                      input logic [SW-1:0] syn, input bit do_rst);
    int   guard;
    exp_t e;
    guard = 0;
    while (!cw_ready && guard < 200) begin
      cw_valid = 1'($urandom_range(0, 1));
      cw_in    = 8'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    cw_valid = 1'b1; cw_in = cw; h_matrix = h;
    @(posedge clk); #1;
    if (!do_rst) begin
      e = model(cw, h, syn);
      e.acc = cyc;
      q.push_back(e);
    end
    cw_valid = 1'b0; cw_in = 8'($urandom); h_matrix = 32'($urandom); syndrome_in = syn;
    @(posedge clk); #1;
    syndrome_in = 4'($urandom);
    if (do_rst) begin
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
    end
  endtask

  // Driver: directed cases first, then randomized items.
  initial begin
    logic [SW*CW-1:0] h;
    logic [SW-1:0]    s;
    int               k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    send(8'hA5, std_h(), 4'h0, 1'b0);
    send(8'hA5, std_h(), 4'h3, 1'b0);
    send(8'h3C, std_h(), 4'hF, 1'b0);
    send(8'hA5, std_h(), 4'h3, 1'b1);
    send(8'h5A, std_h(), 4'h1, 1'b0);
    for (int i = 0; i < 5; i++) send(8'($urandom), std_h(), 4'($urandom_range(1, 8)), 1'b0);
    for (int i = 0; i < 150; i++) begin
      h = ($urandom_range(0, 9) < 7) ? std_h() : 32'($urandom);
      k = $urandom_range(0, 3);
      if (k == 0)      s = 4'h0;
      else if (k == 3) s = 4'($urandom);
      else             s = col_of(h, $urandom_range(0, CW - 1));
      send(8'($urandom), h, s, 1'b0);
    end
    drv_done = 1'b1;
  end

  // Consumer back-pressure, including stalls of several cycles.
  initial begin
    while (!drv_done) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) begin
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    out_ready = 1'b1;
  end

  // Monitor / scoreboard.
  initial begin
    exp_t          cur;
    bit            pv, pr, prst;
    logic [CW-1:0] hd;
    logic [1:0]    hs;
    logic [SW-1:0] hy;
    int            mc, mu;
    pv = 1'b0; pr = 1'b0; prst = 1'b1; mc = 0; mu = 0;
    hd = '0; hs = '0; hy = '0;
    while (!(drv_done && q.size() == 0 && !out_valid) && cyc < 30000) begin
      @(negedge clk);
      if (prst && !rst) begin
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_cw_ready", 32'(cw_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_status", 32'(out_status), 32'd0);
        chk("rst_out_syndrome", 32'(out_syndrome), 32'd0);
      end
      chk("corr_cnt", 32'(corr_cnt), 32'(mc));
      chk("uncorr_cnt", 32'(uncorr_cnt), 32'(mu));
      if (out_valid) begin
        chk("cw_ready_busy", 32'(cw_ready), 32'd0);
        if (!pv) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            cur = q[0];
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat - 1));
            chk("out_data", 32'(out_data), 32'(cur.data));
            chk("out_status", 32'(out_status), 32'(cur.status));
            chk("out_syndrome", 32'(out_syndrome), 32'(cur.syn));
          end
        end else if (!pr) begin
          chk("hold_data", 32'(out_data), 32'(hd));
          chk("hold_status", 32'(out_status), 32'(hs));
          chk("hold_syndrome", 32'(out_syndrome), 32'(hy));
        end
        hd = out_data; hs = out_status; hy = out_syndrome;
        if (out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
`ifdef ECC_ERR_COUNT_EN
          if (out_status == 2'b01 && mc < 3) mc++;
          if (out_status == 2'b10 && mu < 3) mu++;
`endif
        end
      end
      if (rst) begin
        mc = 0; mu = 0;
      end
      pv = out_valid; pr = out_ready; prst = rst;
    end
    if (cyc >= 30000) chk("timeout", 32'd1, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
